// File: rtl/mpe_result_packer.sv
// mpe_result_packer: packs 32-bit matrix PE results into 512-bit lines
// and buffers completed lines in a small FIFO for NRAM write-back.
module mpe_result_packer #(
   parameter  int DEPTH = 4,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = AW + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [31:0]   mpe_result,
   input  logic          mpe_vld,
   input  logic          flush,
   output logic [511:0]  wb_data,
   output logic [15:0]   wb_mask,
   output logic          wb_valid,
   input  logic          wb_ready,
   output logic [CW-1:0] fifo_cnt,
   output logic          overflow
);

   logic [15:0][31:0] pack_q;
   logic [15:0]       mask_q;
   logic [3:0]        lp_q;

   logic [15:0][31:0] line_d;
   logic [15:0]       line_m;
   logic              close;

   logic [511:0]      mem_d [DEPTH];
   logic [15:0]       mem_m [DEPTH];
   logic [CW-1:0]     wr_ptr;
   logic [CW-1:0]     rd_ptr;
   logic              full;
   logic              pop;
   logic              push;

   // candidate line: pack register with the incoming word merged into lane lp
   always_comb begin
      line_d = pack_q;
      line_m = mask_q;
      if (mpe_vld) begin
         line_d[lp_q] = mpe_result;
         line_m[lp_q] = 1'b1;
      end
   end

   assign close = (mpe_vld && lp_q == 4'd15) ||
                  (flush && (mpe_vld || mask_q != 16'd0));

   assign fifo_cnt = wr_ptr - rd_ptr;
   assign full     = fifo_cnt == CW'(DEPTH);
   assign wb_valid = fifo_cnt != '0;
   assign pop      = wb_valid && wb_ready;
   // a pop in the same cycle frees the slot, so a full FIFO still accepts
   assign push     = close && (!full || pop);

   // pack register: accumulate lanes, clear on every line close
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pack_q <= '0;
         mask_q <= '0;
         lp_q   <= '0;
      end else if (close) begin
         pack_q <= '0;
         mask_q <= '0;
         lp_q   <= '0;
      end else if (mpe_vld) begin
         pack_q <= line_d;
         mask_q <= line_m;
         lp_q   <= lp_q + 4'd1;
      end
   end

   // FIFO pointers and sticky overflow flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         overflow <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + CW'(1);
         if (pop)  rd_ptr <= rd_ptr + CW'(1);
         if (close && !push) overflow <= 1'b1;
      end
   end

   // line storage; contents are only visible through the gated read mux
   always_ff @(posedge clk) begin
      if (push) begin
         mem_d[wr_ptr[AW-1:0]] <= line_d;
         mem_m[wr_ptr[AW-1:0]] <= line_m;
      end
   end

   assign wb_data = wb_valid ? mem_d[rd_ptr[AW-1:0]] : '0;
   assign wb_mask = wb_valid ? mem_m[rd_ptr[AW-1:0]] : '0;

endmodule

// File: tb/tb_mpe_result_packer.sv
// tb_mpe_result_packer: scoreboard bench with a queue-based line model
// for mpe_result_packer (directed scenarios followed by random traffic).
module tb_mpe_result_packer;

   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic          clk;
   logic          rst_n;
   logic [31:0]   mpe_result;
   logic          mpe_vld;
   logic          flush;
   logic [511:0]  wb_data;
   logic [15:0]   wb_mask;
   logic          wb_valid;
   logic          wb_ready;
   logic [CW-1:0] fifo_cnt;
   logic          overflow;

   mpe_result_packer #(.DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .mpe_result (mpe_result),
      .mpe_vld    (mpe_vld),
      .flush      (flush),
      .wb_data    (wb_data),
      .wb_mask    (wb_mask),
      .wb_valid   (wb_valid),
      .wb_ready   (wb_ready),
      .fifo_cnt   (fifo_cnt),
      .overflow   (overflow)
   );

   typedef struct {
      logic [511:0] d;
      logic [15:0]  m;
   } line_t;

   int unsigned pq[$];
   line_t       exp_q[$];
   int          m_cnt;
   bit          m_ovf;
   int          n_chk;
   int          n_fail;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] expv);
      n_chk++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, expv);
      end
   endtask

   // next-edge effect of the given inputs on the model
   task automatic model_step(input bit v, input logic [31:0] d,
                             input bit f, input bit r);
      int    n;
      bit    cl;
      bit    pp;
      line_t ln;
      n  = pq.size() + (v ? 1 : 0);
      cl = (v && pq.size() == 15) || (f && n > 0);
      pp = (m_cnt != 0) && r;
      if (v) pq.push_back(d);
      if (cl) begin
         ln.d = '0;
         for (int i = 0; i < pq.size(); i++) ln.d[32*i +: 32] = pq[i];
         ln.m = 16'((32'd1 << n) - 32'd1);
         pq.delete();
         if (m_cnt < DEPTH || pp) begin
            exp_q.push_back(ln);
            m_cnt++;
         end else begin
            m_ovf = 1'b1;
         end
      end
      if (pp) m_cnt--;
   endtask

   task automatic check_state();
      chk("fifo_cnt", 64'(fifo_cnt), 64'(m_cnt));
      chk("overflow", 64'(overflow), 64'(m_ovf));
      chk("wb_valid", 64'(wb_valid), 64'(m_cnt != 0));
   endtask

   task automatic cyc(input bit v, input logic [31:0] d,
                      input bit f, input bit r);
      mpe_vld    = v;
      mpe_result = d;
      flush      = f;
      wb_ready   = r;
      model_step(v, d, f, r);
      @(posedge clk);
      #1;
      check_state();
   endtask

   task automatic idle(input int k);
      for (int i = 0; i < k; i++) cyc(1'b0, 32'd0, 1'b0, 1'b1);
   endtask

   task automatic pulse_reset();
      mpe_vld  = 1'b0;
      flush    = 1'b0;
      wb_ready = 1'b0;
      rst_n    = 1'b0;
      #1;
      chk("rst_wb_valid", 64'(wb_valid), 64'd0);
      chk("rst_wb_mask", 64'(wb_mask), 64'd0);
      chk("rst_wb_data_zero", 64'(wb_data != '0), 64'd0);
      chk("rst_fifo_cnt", 64'(fifo_cnt), 64'd0);
      chk("rst_overflow", 64'(overflow), 64'd0);
      @(negedge clk);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      pq.delete();
      exp_q.delete();
      m_cnt = 0;
      m_ovf = 1'b0;
   endtask

   // monitor: pop the scoreboard on every accepted head line
   initial begin
      line_t        e;
      bit           hold;
      logic [511:0] hd;
      logic [15:0]  hm;
      hold = 1'b0;
      hd   = '0;
      hm   = '0;
      forever begin
         @(negedge clk);
         if (rst_n !== 1'b1) begin
            hold = 1'b0;
            continue;
         end
         if (hold) begin
            n_chk++;
            if (wb_valid !== 1'b1 || wb_data !== hd || wb_mask !== hm) begin
               n_fail++;
               $display("FAIL hold: got mask %0h expected mask %0h",
                        wb_mask, hm);
            end
         end
         if (wb_valid !== 1'b1) begin
            n_chk++;
            if (wb_data !== '0 || wb_mask !== '0) begin
               n_fail++;
               $display("FAIL idle_zero: got mask %0h expected 0", wb_mask);
            end
         end else if (wb_ready === 1'b1) begin
            n_chk++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL extra_line: got mask %0h expected no line",
                        wb_mask);
            end else begin
               e = exp_q.pop_front();
               if (wb_data !== e.d || wb_mask !== e.m) begin
                  n_fail++;
                  $display("FAIL line: got %0h/%0h expected %0h/%0h",
                           wb_mask, wb_data, e.m, e.d);
               end
            end
         end
         hold = (wb_valid === 1'b1) && (wb_ready !== 1'b1);
         hd   = wb_data;
         hm   = wb_mask;
      end
   end

   initial begin
      bit rdy_hi;
      n_chk      = 0;
      n_fail     = 0;
      m_cnt      = 0;
      m_ovf      = 1'b0;
      rst_n      = 1'b0;
      mpe_vld    = 1'b0;
      mpe_result = '0;
      flush      = 1'b0;
      wb_ready   = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_state();
      chk("reset_mask", 64'(wb_mask), 64'd0);
      rst_n = 1'b1;

      // full line of 1..16
      for (int i = 1; i <= 16; i++) cyc(1'b1, 32'(i), 1'b0, 1'b1);
      idle(3);

      // partial flush, then a bare flush on an empty pack
      cyc(1'b1, 32'hA, 1'b0, 1'b1);
      cyc(1'b1, 32'hB, 1'b0, 1'b1);
      cyc(1'b1, 32'hC, 1'b0, 1'b1);
      cyc(1'b0, 32'd0, 1'b1, 1'b1);
      idle(1);
      cyc(1'b0, 32'd0, 1'b1, 1'b1);
      idle(2);

      // flush together with a result, then a fresh line
      for (int i = 0; i < 4; i++) cyc(1'b1, 32'(100 + i), 1'b0, 1'b1);
      cyc(1'b1, 32'h55, 1'b1, 1'b1);
      cyc(1'b1, 32'h77, 1'b0, 1'b1);
      cyc(1'b0, 32'd0, 1'b1, 1'b1);
      idle(3);

      // FIFO full, fifth line closes in a pop cycle
      for (int i = 0; i < 79; i++) cyc(1'b1, 32'(1000 + i), 1'b0, 1'b0);
      cyc(1'b1, 32'd1079, 1'b0, 1'b1);
      idle(6);

      // overflow with back-pressure held
      for (int i = 0; i < 80; i++) cyc(1'b1, 32'(2000 + i), 1'b0, 1'b0);
      idle(8);

      // reset mid-stream with two lines buffered
      for (int i = 0; i < 37; i++) cyc(1'b1, 32'(3000 + i), 1'b0, 1'b0);
      pulse_reset();
      for (int i = 0; i < 16; i++) cyc(1'b1, 32'(4000 + i), 1'b0, 1'b1);
      idle(3);

      // random traffic with alternating ready phases
      rdy_hi = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         if (i % 200 == 0) rdy_hi = ~rdy_hi;
         cyc($urandom_range(0, 3) != 0, $urandom,
             $urandom_range(0, 15) == 0,
             rdy_hi ? ($urandom_range(0, 3) != 0)
                    : ($urandom_range(0, 7) == 0));
      end

      cyc(1'b0, 32'd0, 1'b1, 1'b1);
      idle(10);
      chk("drained", 64'(exp_q.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
